// File: rtl/minifpga_pkg.sv
// Shared types and config-word layout for the MiniFPGA logic cluster.
// The bit offsets depend on K because the LUT_INIT field takes 2**K bits.
package minifpga_pkg;

  typedef enum logic [1:0] {
    UNCFG  = 2'd0,
    SHIFT  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam int LUT_LSB = 0;

  function automatic int cw(input int k);
    return (1 << k) + 4;
  endfunction

  function automatic int dff_en_bit(input int k);
    return (1 << k);
  endfunction

  function automatic int reval_bit(input int k);
    return (1 << k) + 1;
  endfunction

  function automatic int cen_use_bit(input int k);
    return (1 << k) + 2;
  endfunction

  function automatic int cin_sel_bit(input int k);
    return (1 << k) + 3;
  endfunction

endpackage

// File: rtl/minifpga_lc_cell.sv
// One logic cell: a K-input LUT, a ripple-carry bit, and an optional output register.
// On a commit edge the register loads the reset value of the incoming config.
module minifpga_lc_cell
  import minifpga_pkg::*;
#(
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [cw(K)-1:0] cfg,
  input  logic             new_reval,
  input  logic             commit,
  input  logic             run_en,
  input  logic [K-1:0]     lut_in,
  input  logic             cen,
  input  logic             sr,
  input  logic             ci,
  output logic             co,
  output logic             o
);

  localparam int LUT_SZ = 1 << K;

  logic [LUT_SZ-1:0] lut_init;
  logic [K-1:0]      idx;
  logic              lut_o;
  logic              dff_en;
  logic              reval;
  logic              cen_use;
  logic              cin_sel;
  logic              q;

  assign lut_init = cfg[LUT_LSB +: LUT_SZ];
  assign dff_en   = cfg[dff_en_bit(K)];
  assign reval    = cfg[reval_bit(K)];
  assign cen_use  = cfg[cen_use_bit(K)];
  assign cin_sel  = cfg[cin_sel_bit(K)];

  // The top LUT input is replaced by the carry when the cell is used as an adder bit.
  always_comb begin
    idx = lut_in;
    if (cin_sel) idx[K-1] = ci;
  end

  assign lut_o = lut_init[idx];
  assign co    = (lut_in[0] & lut_in[1]) | ((lut_in[0] | lut_in[1]) & ci);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      q <= 1'b0;
    end else if (commit) begin
      q <= new_reval;
    end else if (run_en) begin
      if (sr) q <= reval;
      else if (!cen_use || cen) q <= lut_o;
    end
  end

  assign o = run_en ? (dff_en ? q : lut_o) : 1'b0;

endmodule

// File: rtl/minifpga_lc_cluster.sv
// Cluster of N logic cells with a serial shadow config chain and atomic commit.
// User logic keeps running on the active image while a new one is shifted in.
module minifpga_lc_cluster
  import minifpga_pkg::*;
#(
  parameter int K = 4,
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RESETB,
  input  logic         CFG_EN,
  input  logic         CFG_DIN,
  output logic         CFG_DOUT,
  output logic         CFG_DONE,
  input  logic [N*K-1:0] I,
  input  logic [N-1:0] CEN,
  input  logic [N-1:0] SR,
  input  logic         CI,
  output logic         CO,
  output logic [N-1:0] O,
  output state_e       dbg_state
);

  localparam int CW        = cw(K);
  localparam int CHAIN_LEN = N * CW;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

  state_e               state;
  state_e               state_nxt;
  logic [CHAIN_LEN-1:0] shadow;
  logic [CHAIN_LEN-1:0] shadow_nxt;
  logic [CHAIN_LEN-1:0] active;
  logic [CNT_W-1:0]     cnt;
  logic                 has_cfg;
  logic                 commit;
  logic                 run_en;
  logic [N:0]           c;

  assign shadow_nxt = {shadow[CHAIN_LEN-2:0], CFG_DIN};
  // Counter is zero outside SHIFT, so this can only fire on the last shift of a load.
  assign commit     = CFG_EN && (cnt == CNT_W'(CHAIN_LEN - 1));
  assign run_en     = (state != UNCFG);

  always_comb begin
    state_nxt = state;
    case (state)
      UNCFG:   if (CFG_EN) state_nxt = SHIFT;
      SHIFT:   if (commit) state_nxt = ACTIVE;
      ACTIVE:  if (CFG_EN) state_nxt = SHIFT;
      default: state_nxt = UNCFG;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      state   <= UNCFG;
      shadow  <= '0;
      active  <= '0;
      cnt     <= '0;
      has_cfg <= 1'b0;
    end else begin
      state <= state_nxt;
      if (CFG_EN) begin
        shadow <= shadow_nxt;
        if (commit) begin
          active  <= shadow_nxt;
          cnt     <= '0;
          has_cfg <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // has_cfg is only cleared by reset, so it covers ACTIVE and a reload from ACTIVE.
  assign CFG_DONE  = has_cfg;
  assign CFG_DOUT  = shadow[CHAIN_LEN-1];
  assign dbg_state = state;
  assign c[0]      = CI;
  assign CO        = c[N];

  for (genvar g = 0; g < N; g++) begin : g_cell
    minifpga_lc_cell #(.K(K)) u_cell (
      .clk       (CLK),
      .resetb    (RESETB),
      .cfg       (active[g*CW +: CW]),
      .new_reval (shadow_nxt[g*CW + reval_bit(K)]),
      .commit    (commit),
      .run_en    (run_en),
      .lut_in    (I[g*K +: K]),
      .cen       (CEN[g]),
      .sr        (SR[g]),
      .ci        (c[g]),
      .co        (c[g+1]),
      .o         (O[g])
    );
  end

endmodule

// File: tb/tb_minifpga_lc_cluster.sv
// Directed bench for a K=4, N=2 cluster plus a second cluster daisy-chained
// behind it through CFG_DOUT.
module tb_minifpga_lc_cluster;
  import minifpga_pkg::*;

  // cell1 = buffer I0, registered, REVAL=1, CEN_USE=1; cell0 = AND4, combinational
  localparam logic [39:0] IMG_LOGIC = 40'h7AAAA08000;
  // both cells: XOR(I0, I1, carry) with CIN_SEL=1 -> 2-bit adder
  localparam logic [39:0] IMG_ADDER = 40'h8996689966;

  logic       clk;
  logic       resetb;
  logic       cfg_en;
  logic       cfg_din;
  logic       chain_mode;
  logic [7:0] i_a, i_b;
  logic [1:0] cen, sr;
  logic       ci_a, ci_b;
  logic       dout_a, dout_b, done_a, done_b, co_a, co_b;
  logic [1:0] o_a, o_b;
  state_e     st_a, st_b;
  logic       cfg_en_b;

  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  assign cfg_en_b = cfg_en && chain_mode;

  minifpga_lc_cluster #(.K(4), .N(2)) dut (
    .CLK(clk), .RESETB(resetb), .CFG_EN(cfg_en), .CFG_DIN(cfg_din),
    .CFG_DOUT(dout_a), .CFG_DONE(done_a), .I(i_a), .CEN(cen), .SR(sr),
    .CI(ci_a), .CO(co_a), .O(o_a), .dbg_state(st_a)
  );

  minifpga_lc_cluster #(.K(4), .N(2)) dut_b (
    .CLK(clk), .RESETB(resetb), .CFG_EN(cfg_en_b), .CFG_DIN(dout_a),
    .CFG_DOUT(dout_b), .CFG_DONE(done_b), .I(i_b), .CEN(2'b00), .SR(2'b00),
    .CI(ci_b), .CO(co_b), .O(o_b), .dbg_state(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drivers: inputs change 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic shift_one(input logic b);
    cfg_din = b;
    cfg_en  = 1'b1;
    tick();
    cfg_en  = 1'b0;
  endtask

  task automatic load(input logic [39:0] img, input int nbits);
    for (int k = 39; k > 39 - nbits; k--) shift_one(img[k]);
  endtask

  // {I, CEN, SR, expected O[1]} for the registered cell
  logic [7:0] v_i   [7] = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h00};
  logic [1:0] v_cen [7] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10};
  logic [1:0] v_sr  [7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10};
  logic       v_exp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    resetb = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0; chain_mode = 1'b0;
    i_a = '0; i_b = '0; cen = '0; sr = '0; ci_a = 1'b0; ci_b = 1'b0;
    tick(); tick();
    check("rst_state", 32'(st_a), 32'(UNCFG));
    check("rst_done", 32'(done_a), 0);
    check("rst_dout", 32'(dout_a), 0);
    check("rst_o", 32'(o_a), 0);
    resetb = 1'b1;
    tick();

    // first load: done stays low until the commit edge
    load(IMG_LOGIC, 39);
    check("first_shift_state", 32'(st_a), 32'(SHIFT));
    check("first_shift_done", 32'(done_a), 0);
    shift_one(IMG_LOGIC[0]);
    check("commit_state", 32'(st_a), 32'(ACTIVE));
    check("commit_done", 32'(done_a), 1);
    check("commit_reval", 32'(o_a[1]), 1);
    i_a = 8'h0F; #1;
    check("and4_hit", 32'(o_a[0]), 1);
    i_a = 8'h0E; #1;
    check("and4_miss", 32'(o_a[0]), 0);

    // registered cell: SR priority, clock enable, hold
    cen = 2'b10; i_a = 8'h00; #1;
    check("reg_no_comb_path", 32'(o_a[1]), 1);
    for (int k = 0; k < 7; k++) exp_q.push_back(32'(v_exp[k]));
    for (int k = 0; k < 7; k++) begin
      i_a = v_i[k]; cen = v_cen[k]; sr = v_sr[k];
      tick();
      check($sformatf("reg_vec%0d", k), 32'(o_a[1]), exp_q.pop_front());
    end
    cen = '0; sr = '0; i_a = '0;

    // reconfigure to the adder from ACTIVE
    load(IMG_ADDER, 20);
    check("reload_done_mid", 32'(done_a), 1);
    load(IMG_ADDER << 20, 20);
    i_a = 8'h13; ci_a = 1'b0; #1;   // A=11 B=01
    check("add_11_01_o", 32'(o_a), 0);
    check("add_11_01_co", 32'(co_a), 1);
    i_a = 8'h03; ci_a = 1'b1; #1;   // A=01 B=01 +1
    check("add_01_01_c1_o", 32'(o_a), 3);
    check("add_01_01_c1_co", 32'(co_a), 0);
    i_a = 8'h10; ci_a = 1'b0; #1;   // A=10 B=00
    check("add_10_00_o", 32'(o_a), 2);
    check("add_10_00_co", 32'(co_a), 0);

    // reload with a paused enable: old adder keeps working until the commit edge
    i_a = 8'h0F; ci_a = 1'b0;
    for (int k = 39; k >= 0; k--) begin
      shift_one(IMG_LOGIC[k]);
      if (k % 10 == 5) begin
        check("paused_old_o", 32'(o_a), 2);
        check("paused_done", 32'(done_a), 1);
      end
      if (k != 0) tick();
    end
    check("paused_new_o", 32'(o_a), 3);
    check("paused_new_done", 32'(done_a), 1);

    // reset part-way through a load
    load(IMG_ADDER, 17);
    check("midload_o", 32'(o_a), 3);
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    check("midrst_done", 32'(done_a), 0);
    check("midrst_o", 32'(o_a), 0);
    check("midrst_dout", 32'(dout_a), 0);
    check("midrst_state", 32'(st_a), 32'(UNCFG));
    load(IMG_ADDER, 40);
    i_a = 8'h13; ci_a = 1'b0; #1;
    check("reload_done", 32'(done_a), 1);
    check("reload_add_o", 32'(o_a), 0);
    check("reload_add_co", 32'(co_a), 1);

    // daisy chain: first 40 bits end up in the downstream cluster
    check("chain_b_idle", 32'(done_b), 0);
    chain_mode = 1'b1;
    load(IMG_ADDER, 40);
    load(IMG_LOGIC, 40);
    chain_mode = 1'b0;
    i_a = 8'h0F; #1;
    check("chain_a_o", 32'(o_a), 3);
    check("chain_a_done", 32'(done_a), 1);
    i_b = 8'h13; ci_b = 1'b0; #1;
    check("chain_b_o", 32'(o_b), 0);
    check("chain_b_co", 32'(co_b), 1);
    check("chain_b_done", 32'(done_b), 1);
    i_b = 8'h03; ci_b = 1'b1; #1;
    check("chain_b_o2", 32'(o_b), 3);
    check("chain_b_co2", 32'(co_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
